// File: rtl/quadrato_ctrl_if.sv
// Sprite controller bus: frame sync, player buttons, selection in;
// committed sprite position, border enable and status out.
interface quadrato_ctrl_if;
    logic        VSYNC;
    logic        BTN_SX;
    logic        BTN_DX;
    logic        BTN_SU;
    logic        BTN_GIU;
    logic        SELEZIONE;
    logic [10:0] X_POS;
    logic [10:0] Y_POS;
    logic        CORNICE_EN;
    logic        AGGIORNATO;
    logic        BUSY;

    // Source of frame sync and buttons, consumer of the sprite state
    modport master (
        output VSYNC, BTN_SX, BTN_DX, BTN_SU, BTN_GIU, SELEZIONE,
        input  X_POS, Y_POS, CORNICE_EN, AGGIORNATO, BUSY
    );

    // The controller itself
    modport slave (
        input  VSYNC, BTN_SX, BTN_DX, BTN_SU, BTN_GIU, SELEZIONE,
        output X_POS, Y_POS, CORNICE_EN, AGGIORNATO, BUSY
    );
endinterface

// File: rtl/quadrato_ctrl.sv
// Per-frame motion and border-blink controller for one square sprite.
// Button requests are latched between frames; on each VSYNC rising edge a
// short sequence computes the new centre (X wraps, Y clamps) and commits
// X_POS/Y_POS together, so the pixel pipeline never sees a half update.
module quadrato_ctrl #(
    parameter int unsigned H         = 1280,
    parameter int unsigned V         = 1024,
    parameter int unsigned ALTEZZA   = 100,
    parameter int unsigned PASSO     = 4,
    parameter int unsigned X_INIT    = 640,
    parameter int unsigned Y_INIT    = 512,
    parameter int unsigned LAMPEGGIO = 30
) (
    input  logic            CLK,
    input  logic            RST_N,
    quadrato_ctrl_if.slave  bus
);

    localparam int unsigned POS_W = 11;
    localparam int unsigned EXT_W = 12;
    localparam int unsigned CNT_W = (LAMPEGGIO > 1) ? $clog2(LAMPEGGIO) : 1;

    localparam logic [EXT_W-1:0] H_E      = EXT_W'(H);
    localparam logic [EXT_W-1:0] PASSO_E  = EXT_W'(PASSO);
    localparam logic [EXT_W-1:0] Y_MIN_E  = EXT_W'(ALTEZZA / 2);
    localparam logic [EXT_W-1:0] Y_MAX_E  = EXT_W'(V - 1 - ALTEZZA / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAMPEGGIO - 1);

    localparam logic [2:0] ATTESA    = 3'd0;
    localparam logic [2:0] CATTURA   = 3'd1;
    localparam logic [2:0] CALCOLO_X = 3'd2;
    localparam logic [2:0] CALCOLO_Y = 3'd3;
    localparam logic [2:0] COMMIT    = 3'd4;

    // Request bit order: {SX, DX, SU, GIU}
    localparam int unsigned R_SX  = 3;
    localparam int unsigned R_DX  = 2;
    localparam int unsigned R_SU  = 1;
    localparam int unsigned R_GIU = 0;

    logic [2:0]       state,      state_nxt;
    logic [3:0]       req,        req_nxt;
    logic [3:0]       wreq,       wreq_nxt;
    logic [POS_W-1:0] wx,         wx_nxt;
    logic [POS_W-1:0] wy,         wy_nxt;
    logic [POS_W-1:0] x_pos,      x_pos_nxt;
    logic [POS_W-1:0] y_pos,      y_pos_nxt;
    logic             cornice,    cornice_nxt;
    logic             aggiornato, aggiornato_nxt;
    logic             busy,       busy_nxt;
    logic [CNT_W-1:0] cnt,        cnt_nxt;
    logic             sel_prev,   sel_prev_nxt;
    logic             vsync_d;

    logic [3:0]       btn;
    logic [EXT_W-1:0] x_ext, x_right, x_left;
    logic [EXT_W-1:0] y_ext, y_up, y_down_raw, y_down;

    assign btn = {bus.BTN_SX, bus.BTN_DX, bus.BTN_SU, bus.BTN_GIU};

    // State and datapath registers
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= ATTESA;
            req        <= '0;
            wreq       <= '0;
            wx         <= '0;
            wy         <= '0;
            x_pos      <= POS_W'(X_INIT);
            y_pos      <= POS_W'(Y_INIT);
            cornice    <= 1'b0;
            aggiornato <= 1'b0;
            busy       <= 1'b0;
            cnt        <= '0;
            sel_prev   <= 1'b0;
            vsync_d    <= 1'b1;
        end else begin
            state      <= state_nxt;
            req        <= req_nxt;
            wreq       <= wreq_nxt;
            wx         <= wx_nxt;
            wy         <= wy_nxt;
            x_pos      <= x_pos_nxt;
            y_pos      <= y_pos_nxt;
            cornice    <= cornice_nxt;
            aggiornato <= aggiornato_nxt;
            busy       <= busy_nxt;
            cnt        <= cnt_nxt;
            sel_prev   <= sel_prev_nxt;
            vsync_d    <= bus.VSYNC;
        end
    end

    // Candidate moves: X wraps modulo H, Y saturates at the sprite limits
    always_comb begin
        x_ext   = {1'b0, wx};
        x_right = x_ext + PASSO_E;
        if (x_right >= H_E) begin
            x_right = x_right - H_E;
        end
        x_left  = (x_ext < PASSO_E) ? (x_ext + H_E - PASSO_E) : (x_ext - PASSO_E);

        y_ext      = {1'b0, wy};
        y_up       = (y_ext < (Y_MIN_E + PASSO_E)) ? Y_MIN_E : (y_ext - PASSO_E);
        y_down_raw = y_ext + PASSO_E;
        y_down     = (y_down_raw > Y_MAX_E) ? Y_MAX_E : y_down_raw;
    end

    // Next-state sequencing, request latching, commit and blink update
    always_comb begin
        state_nxt      = state;
        req_nxt        = req | btn;
        wreq_nxt       = wreq;
        wx_nxt         = wx;
        wy_nxt         = wy;
        x_pos_nxt      = x_pos;
        y_pos_nxt      = y_pos;
        cornice_nxt    = cornice;
        aggiornato_nxt = 1'b0;
        cnt_nxt        = cnt;
        sel_prev_nxt   = sel_prev;

        case (state)
            ATTESA: begin
                if (bus.VSYNC && !vsync_d) begin
                    state_nxt = CATTURA;
                end
            end
            CATTURA: begin
                wreq_nxt  = req;
                req_nxt   = btn;
                wx_nxt    = x_pos;
                wy_nxt    = y_pos;
                state_nxt = CALCOLO_X;
            end
            CALCOLO_X: begin
                if (wreq[R_DX] && !wreq[R_SX]) begin
                    wx_nxt = POS_W'(x_right);
                end else if (wreq[R_SX] && !wreq[R_DX]) begin
                    wx_nxt = POS_W'(x_left);
                end
                state_nxt = CALCOLO_Y;
            end
            CALCOLO_Y: begin
                if (wreq[R_SU] && !wreq[R_GIU]) begin
                    wy_nxt = POS_W'(y_up);
                end else if (wreq[R_GIU] && !wreq[R_SU]) begin
                    wy_nxt = POS_W'(y_down);
                end
                state_nxt = COMMIT;
            end
            COMMIT: begin
                x_pos_nxt      = wx;
                y_pos_nxt      = wy;
                aggiornato_nxt = 1'b1;
                if (!bus.SELEZIONE) begin
                    cornice_nxt = 1'b0;
                    cnt_nxt     = '0;
                end else if (!sel_prev) begin
                    cornice_nxt = 1'b1;
                    cnt_nxt     = '0;
                end else if (cnt == CNT_LAST) begin
                    cornice_nxt = ~cornice;
                    cnt_nxt     = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
                sel_prev_nxt = bus.SELEZIONE;
                state_nxt    = ATTESA;
            end
            default: begin
                state_nxt = ATTESA;
            end
        endcase

        busy_nxt = (state_nxt != ATTESA);
    end

    // Registered outputs
    assign bus.X_POS      = x_pos;
    assign bus.Y_POS      = y_pos;
    assign bus.CORNICE_EN = cornice;
    assign bus.AGGIORNATO = aggiornato;
    assign bus.BUSY       = busy;

endmodule

// File: tb/tb_quadrato_ctrl.sv
// Directed bench for quadrato_ctrl: three instances share stimulus and start
// from different centres so wrap and clamp boundaries are reachable quickly.
module tb_quadrato_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vsync = 1'b1;
    logic [3:0] btn = 4'b0000;   // {SX, DX, SU, GIU}
    logic       sel = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    quadrato_ctrl_if ifa ();
    quadrato_ctrl_if ifb ();
    quadrato_ctrl_if ifc ();

    assign ifa.VSYNC = vsync;   assign ifb.VSYNC = vsync;   assign ifc.VSYNC = vsync;
    assign ifa.BTN_SX = btn[3]; assign ifb.BTN_SX = btn[3]; assign ifc.BTN_SX = btn[3];
    assign ifa.BTN_DX = btn[2]; assign ifb.BTN_DX = btn[2]; assign ifc.BTN_DX = btn[2];
    assign ifa.BTN_SU = btn[1]; assign ifb.BTN_SU = btn[1]; assign ifc.BTN_SU = btn[1];
    assign ifa.BTN_GIU = btn[0]; assign ifb.BTN_GIU = btn[0]; assign ifc.BTN_GIU = btn[0];
    assign ifa.SELEZIONE = sel; assign ifb.SELEZIONE = sel; assign ifc.SELEZIONE = sel;

    quadrato_ctrl #(.LAMPEGGIO(2)) u_a (.CLK(clk), .RST_N(rst_n), .bus(ifa));
    quadrato_ctrl #(.LAMPEGGIO(2), .X_INIT(1278), .Y_INIT(52)) u_b (.CLK(clk), .RST_N(rst_n), .bus(ifb));
    quadrato_ctrl #(.LAMPEGGIO(2), .X_INIT(640), .Y_INIT(971)) u_c (.CLK(clk), .RST_N(rst_n), .bus(ifc));

    typedef struct {
        logic [3:0] b;
        logic       s;
        int         ax, ay, bx, by, cx, cy;
        logic       cor;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulse buttons for one cycle, wait, raise VSYNC, then time the commit
    task automatic do_frame(input logic [3:0] b, input logic s, input int gap, input string tag);
        int n;
        bit seen;
        @(posedge clk); #1; btn = b; sel = s;
        @(posedge clk); #1; btn = 4'b0000;
        repeat (gap) @(posedge clk);
        #1; vsync = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) chk({tag, " busy_after_edge"}, int'(ifa.BUSY), 1);
            if (ifa.AGGIORNATO) seen = 1'b1;
        end
        chk({tag, " latency"}, seen ? n - 1 : -1, 4);
        @(posedge clk); #1;
        chk({tag, " agg_one_cycle"}, int'(ifa.AGGIORNATO), 0);
        chk({tag, " busy_idle"}, int'(ifa.BUSY), 0);
        vsync = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int agg_cnt;
        int busy_cnt;

        //             b        s     ax   ay   bx    by  cx   cy   cor
        vecs[0]  = '{4'b0100, 1'b0, 644, 512,    2, 52, 644, 971, 1'b0};
        vecs[1]  = '{4'b1000, 1'b0, 640, 512, 1278, 52, 640, 971, 1'b0};
        vecs[2]  = '{4'b1100, 1'b0, 640, 512, 1278, 52, 640, 971, 1'b0};
        vecs[3]  = '{4'b0010, 1'b0, 640, 508, 1278, 50, 640, 967, 1'b0};
        vecs[4]  = '{4'b0010, 1'b0, 640, 504, 1278, 50, 640, 963, 1'b0};
        vecs[5]  = '{4'b0001, 1'b0, 640, 508, 1278, 54, 640, 967, 1'b0};
        vecs[6]  = '{4'b0001, 1'b0, 640, 512, 1278, 58, 640, 971, 1'b0};
        vecs[7]  = '{4'b0001, 1'b0, 640, 516, 1278, 62, 640, 973, 1'b0};
        vecs[8]  = '{4'b0001, 1'b0, 640, 520, 1278, 66, 640, 973, 1'b0};
        vecs[9]  = '{4'b0000, 1'b1, 640, 520, 1278, 66, 640, 973, 1'b1};
        vecs[10] = '{4'b0000, 1'b1, 640, 520, 1278, 66, 640, 973, 1'b1};
        vecs[11] = '{4'b0000, 1'b1, 640, 520, 1278, 66, 640, 973, 1'b0};
        vecs[12] = '{4'b0000, 1'b1, 640, 520, 1278, 66, 640, 973, 1'b0};
        vecs[13] = '{4'b0000, 1'b1, 640, 520, 1278, 66, 640, 973, 1'b1};
        vecs[14] = '{4'b0000, 1'b0, 640, 520, 1278, 66, 640, 973, 1'b0};
        vecs[15] = '{4'b0011, 1'b0, 640, 520, 1278, 66, 640, 973, 1'b0};

        // Reset with VSYNC high, then release: no spurious update
        rst_n = 1'b0;
        vsync = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst a_x", int'(ifa.X_POS), 640);
        chk("rst a_y", int'(ifa.Y_POS), 512);
        chk("rst cornice", int'(ifa.CORNICE_EN), 0);
        chk("rst busy", int'(ifa.BUSY), 0);
        chk("rst agg", int'(ifa.AGGIORNATO), 0);
        chk("rst b_x", int'(ifb.X_POS), 1278);
        chk("rst c_y", int'(ifc.Y_POS), 971);
        rst_n = 1'b1;
        agg_cnt = 0;
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ifa.AGGIORNATO) agg_cnt++;
            if (ifa.BUSY) busy_cnt++;
        end
        chk("rst_exit agg_pulses", agg_cnt, 0);
        chk("rst_exit busy_cycles", busy_cnt, 0);
        chk("rst_exit a_x", int'(ifa.X_POS), 640);
        vsync = 1'b0;
        repeat (2) @(posedge clk);

        // Table of frames: moves, wrap, clamp, blink
        for (int i = 0; i < 16; i++) begin
            do_frame(vecs[i].b, vecs[i].s, 2, $sformatf("v%0d", i));
            chk($sformatf("v%0d a_x", i), int'(ifa.X_POS), vecs[i].ax);
            chk($sformatf("v%0d a_y", i), int'(ifa.Y_POS), vecs[i].ay);
            chk($sformatf("v%0d b_x", i), int'(ifb.X_POS), vecs[i].bx);
            chk($sformatf("v%0d b_y", i), int'(ifb.Y_POS), vecs[i].by);
            chk($sformatf("v%0d c_x", i), int'(ifc.X_POS), vecs[i].cx);
            chk($sformatf("v%0d c_y", i), int'(ifc.Y_POS), vecs[i].cy);
            chk($sformatf("v%0d cornice", i), int'(ifa.CORNICE_EN), int'(vecs[i].cor));
        end

        // One-cycle SX pulse well before the frame is still honoured
        do_frame(4'b1000, 1'b0, 10, "sticky");
        chk("sticky a_x", int'(ifa.X_POS), 636);
        chk("sticky b_x", int'(ifb.X_POS), 1274);
        chk("sticky a_y", int'(ifa.Y_POS), 520);

        // Second VSYNC rise while busy is ignored
        repeat (2) @(posedge clk);
        #1; vsync = 1'b1;
        agg_cnt = 0;
        for (int j = 1; j <= 16; j++) begin
            @(posedge clk); #1;
            if (ifa.AGGIORNATO) agg_cnt++;
            if (j == 2) vsync = 1'b0;
            if (j == 3) vsync = 1'b1;
        end
        chk("double_vsync agg_pulses", agg_cnt, 1);
        chk("double_vsync a_x", int'(ifa.X_POS), 636);
        vsync = 1'b0;
        repeat (2) @(posedge clk);

        // Reset during CALCOLO_Y discards the update
        #1; btn = 4'b0001;
        @(posedge clk); #1; btn = 4'b0000;
        repeat (2) @(posedge clk);
        #1; vsync = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst busy_before", int'(ifa.BUSY), 1);
        rst_n = 1'b0;
        vsync = 1'b0;
        agg_cnt = 0;
        for (int j = 0; j < 2; j++) begin
            @(posedge clk); #1;
            if (ifa.AGGIORNATO) agg_cnt++;
        end
        chk("midrst a_x", int'(ifa.X_POS), 640);
        chk("midrst a_y", int'(ifa.Y_POS), 512);
        chk("midrst b_y", int'(ifb.Y_POS), 52);
        chk("midrst busy", int'(ifa.BUSY), 0);
        rst_n = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(posedge clk); #1;
            if (ifa.AGGIORNATO) agg_cnt++;
        end
        chk("midrst agg_pulses", agg_cnt, 0);

        // Requests were cleared by reset: an empty frame leaves position alone
        do_frame(4'b0000, 1'b0, 2, "post_rst");
        chk("post_rst a_x", int'(ifa.X_POS), 640);
        chk("post_rst a_y", int'(ifa.Y_POS), 512);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/quadrato_ctrl.md
Name: quadrato_ctrl

Overview:
Per-frame motion and highlight controller for one square sprite on the 1280-wide display.
- Latches player direction buttons between frames.
- On each VSYNC rising edge, runs a short sequencing FSM that computes the new sprite centre. X wraps horizontally; Y is clamped vertically.
- Commits X_POS/Y_POS atomically and drives the blink enable for the sprite's border frame.
- Outputs feed the rectangle/border hit-test blocks in the pixel pipeline.

Parameters:
H, 1280, horizontal extent in pixels; X wraps modulo H
V, 1024, vertical extent in pixels
ALTEZZA, 100, sprite height; Y limits derive from ALTEZZA/2
PASSO, 4, pixels moved per frame per axis
X_INIT, 640, reset X centre (must be < H)
Y_INIT, 512, reset Y centre (must lie within Y limits)
LAMPEGGIO, 30, frames per border-blink half-period (>= 1)

Ports:
CLK  in  1  system/pixel clock
RST_N  in  1  synchronous active-low reset
VSYNC  in  1  frame sync level, synchronous to CLK
BTN_SX  in  1  move left request
BTN_DX  in  1  move right request
BTN_SU  in  1  move up request (Y decreases)
BTN_GIU  in  1  move down request (Y increases)
SELEZIONE  in  1  sprite selected; enables border blink
X_POS  out  11  committed centre X
Y_POS  out  11  committed centre Y
CORNICE_EN  out  1  border frame visible
AGGIORNATO  out  1  one-cycle pulse: new position committed
BUSY  out  1  high while FSM not in ATTESA

Behaviour:
- One clock (CLK); reset is synchronous and active-low (RST_N). All state is updated on the rising edge of CLK.
- Reset (RST_N=0 at a CLK edge):
  - X_POS=X_INIT, Y_POS=Y_INIT, CORNICE_EN=0, AGGIORNATO=0.
  - FSM=ATTESA, sticky requests=0, blink counter=0, sel_prev=0.
  - vsync_d=1, so a high VSYNC at reset exit is not treated as an edge.
  - Reset mid-sequence discards the in-flight update; no AGGIORNATO pulse.
- Sticky requests: each cycle, req |= {SX,DX,SU,GIU}. In CATTURA, req is cleared, except for buttons high in that same cycle, which are retained.
- Edge detect: vsync_d <= VSYNC every cycle. Edge = VSYNC & ~vsync_d, evaluated only in ATTESA. Edges while BUSY are ignored.
- FSM states, one cycle each except ATTESA:
  - ATTESA: on edge -> CATTURA.
  - CATTURA: snapshot req into working bits, load working X/Y from X_POS/Y_POS -> CALCOLO_X.
  - CALCOLO_X: move right only if DX&~SX; move left only if SX&~DX; otherwise X unchanged.
    - Right: x+PASSO; if >= H, subtract H.
    - Left: if x < PASSO, x+H-PASSO, else x-PASSO.
    - Intermediates are 12 bits; the result is always in 0..H-1.
    - Then -> CALCOLO_Y.
  - CALCOLO_Y: Y_MIN=ALTEZZA/2, Y_MAX=V-1-ALTEZZA/2.
    - Up only if SU&~GIU: y < Y_MIN+PASSO ? Y_MIN : y-PASSO.
    - Down only if GIU&~SU: y+PASSO > Y_MAX ? Y_MAX : y+PASSO.
    - Otherwise Y unchanged. Then -> COMMIT.
  - COMMIT: X_POS/Y_POS <= working values; AGGIORNATO <= 1; blink update; -> ATTESA.
- Latency: if an edge is sampled at CLK edge k, new X_POS/Y_POS and AGGIORNATO=1 appear after edge k+4, for exactly one cycle of AGGIORNATO. BUSY is high from after edge k through COMMIT.
- Outputs never change outside COMMIT, so there is no mid-frame tearing.
- Blink (evaluated in COMMIT, sampling SELEZIONE):
  - SELEZIONE=0: CORNICE_EN<=0, cnt<=0.
  - SELEZIONE=1 & sel_prev=0: CORNICE_EN<=1, cnt<=0.
  - Else if cnt==LAMPEGGIO-1: cnt<=0, toggle CORNICE_EN. Otherwise cnt++.
  - sel_prev <= SELEZIONE.

Test Plan:
1. RST_N=0 for 2 cycles with VSYNC=1 -> X_POS=640, Y_POS=512, CORNICE_EN=0, BUSY=0. Releasing reset with VSYNC still high causes no update.
2. BTN_DX held, one VSYNC rise -> X_POS=644 and AGGIORNATO=1 exactly one cycle, 4 cycles after the edge is sampled. Y_POS remains 512.
3. Wrap: X_POS=1278 plus DX -> 2. X_POS=2 plus SX -> 1278. SX and DX both held -> X unchanged.
4. Clamp: Y=52 plus SU -> 50. Y=50 plus SU -> 50. Y=971 plus GIU -> 973. Y=973 plus GIU -> 973.
5. Stickiness and busy:
   - BTN_SX pulsed for 1 cycle mid-frame -> next frame X-4.
   - A second VSYNC rise during BUSY -> no extra update.
   - RST_N=0 during CALCOLO_Y -> position returns to 640/512, no AGGIORNATO.
6. Blink with LAMPEGGIO=2 and SELEZIONE=1 over 5 frames -> CORNICE_EN after each commit = 1,1,0,0,1. Then SELEZIONE=0 -> 0 at the next commit.
